jtag_host_shifter: RTL and testbench



---
 rtl/jtag_host_pkg.sv | 64 ++++++
 rtl/jtag_host_shifter_tck_gen.sv | 49 ++++
 rtl/jtag_host_shifter.sv | 148 ++++++++++++++
 tb/tb_jtag_host_shifter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_host_pkg.sv
// Shared definitions for the JTAG host shifter: op codes, FSM states and TMS sequencing.
// Sequencing helpers are pure functions of (op, length, period index).
package jtag_host_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_IR    = 2'd1,
    OP_DR    = 2'd2,
    OP_IDLE  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RESP
  } state_e;

  localparam int RESET_LEN = 6;
  localparam int IR_HDR    = 4;
  localparam int DR_HDR    = 3;
  localparam int TRAILER   = 2;

  function automatic logic [7:0] hdr_len(op_e op);
    return (op == OP_IR) ? 8'(IR_HDR) : 8'(DR_HDR);
  endfunction

  function automatic logic [7:0] num_periods(op_e op, logic [6:0] len);
    logic [7:0] n;
    case (op)
      OP_RESET: n = 8'(RESET_LEN);
      OP_IDLE:  n = {1'b0, len};
      default:  n = (len == 7'd0) ? 8'd0 : hdr_len(op) + {1'b0, len} + 8'(TRAILER);
    endcase
    return n;
  endfunction

  function automatic logic in_shift(op_e op, logic [6:0] len, logic [7:0] k);
    logic r;
    r = ((op == OP_IR) || (op == OP_DR)) && (k >= hdr_len(op)) &&
        (k < hdr_len(op) + {1'b0, len});
    return r;
  endfunction

  // Headers walk Run-Test/Idle to Shift-xR; the last shift bit exits, trailer goes Update then Idle.
  function automatic logic period_tms(op_e op, logic [6:0] len, logic [7:0] k);
    logic [7:0] hdr;
    logic [7:0] sh_end;
    logic       r;
    hdr    = hdr_len(op);
    sh_end = hdr + {1'b0, len};
    r      = 1'b0;
    case (op)
      OP_RESET: r = (k < 8'(RESET_LEN - 1));
      OP_IDLE:  r = 1'b0;
      default: begin
        if (k < hdr)         r = (k < hdr - 8'd2);
        else if (k < sh_end) r = (k == sh_end - 8'd1);
        else                 r = (k == sh_end);
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jtag_host_shifter_tck_gen.sv
// TCK divider: low phase then high phase of CLK_DIV clks each; pulses flag the edge that ends each phase.
// Held in reset (low phase, count 0) whenever en_i is low, so each enable starts a fresh low phase.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tck,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic period_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ph_q, ph_d;
  logic          last;

  assign last        = (cnt_q == CW'(CLK_DIV - 1));
  assign tck         = ph_q;
  assign rise_pulse  = en_i && !ph_q && last;
  assign fall_pulse  = en_i && ph_q && last;
  assign period_done = en_i && ph_q && last;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    ph_d  = ph_q;
    if (!en_i) begin
      cnt_d = '0;
      ph_d  = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      ph_d  = ~ph_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/jtag_host_shifter.sv
// On-chip JTAG initiator: runs TAP reset / IR scan / DR scan / idle commands, returns captured TDO.
// Optional jtag_trst_n output when JTAG_HOST_TRST_EN is defined.
module jtag_host_shifter #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_tdi,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_tdo,
  output logic               busy,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  logic               jtag_tdo
`ifdef JTAG_HOST_TRST_EN
  ,
  output logic               jtag_trst_n
`endif
);
  import jtag_host_pkg::*;

  state_e             state_q;
  op_e                op_q, op_d;
  logic [6:0]         len_q, len_d;
  logic [7:0]         nper_q, nper_d;
  logic [7:0]         per_q, per_nxt;
  logic [MAX_LEN-1:0] tdi_q, cap_q, mask_q, rsp_tdo_q;
  logic               rsp_valid_q, tms_q, jtag_tdi_q;
  logic               rise_pulse, fall_pulse, period_done;
  logic               accept;

  assign op_d      = op_e'(cmd_op);
  assign len_d     = (cmd_len > 7'(MAX_LEN)) ? 7'(MAX_LEN) : cmd_len;
  assign nper_d    = num_periods(op_d, len_d);
  assign per_nxt   = per_q + 8'd1;
  assign cmd_ready = (state_q == S_IDLE) && !rsp_valid_q;
  assign accept    = cmd_valid && cmd_ready;

  assign busy      = (state_q == S_RUN);
  assign rsp_valid = rsp_valid_q;
  assign rsp_tdo   = rsp_tdo_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = jtag_tdi_q;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q == S_RUN),
    .tck         (jtag_tck),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .period_done (period_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_RESET;
      len_q       <= '0;
      nper_q      <= '0;
      per_q       <= '0;
      tdi_q       <= '0;
      cap_q       <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tdo_q   <= '0;
      tms_q       <= 1'b1;
      jtag_tdi_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q       <= op_d;
            len_q      <= len_d;
            nper_q     <= nper_d;
            per_q      <= '0;
            tdi_q      <= cmd_tdi;
            cap_q      <= '0;
            mask_q     <= MAX_LEN'(1);
            jtag_tdi_q <= 1'b0;
            if (nper_d == 8'd0) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_tdo_q   <= '0;
            end else begin
              state_q <= S_RUN;
              tms_q   <= period_tms(op_d, len_d, 8'd0);
            end
          end
        end
        S_RUN: begin
          // TDO is captured on the clk where TCK rises, into the bit selected by the one-hot mask.
          if (rise_pulse && in_shift(op_q, len_q, per_q)) begin
            cap_q  <= jtag_tdo ? (cap_q | mask_q) : cap_q;
            mask_q <= mask_q << 1;
          end
          if (period_done && (per_q == nper_q - 8'd1)) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_tdo_q   <= cap_q;
            jtag_tdi_q  <= 1'b0;
          end else if (fall_pulse) begin
            per_q <= per_nxt;
            tms_q <= period_tms(op_q, len_q, per_nxt);
            if (in_shift(op_q, len_q, per_nxt)) begin
              jtag_tdi_q <= tdi_q[0];
              tdi_q      <= tdi_q >> 1;
            end else begin
              jtag_tdi_q <= 1'b0;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef JTAG_HOST_TRST_EN
  logic trst_q;

  // TRST is asserted for all but the final period of a RESET op.
  always_ff @(posedge clk) begin
    if (rst) begin
      trst_q <= 1'b1;
    end else if (accept) begin
      trst_q <= (op_d != OP_RESET) || (nper_d == 8'd0);
    end else if ((state_q == S_RUN) && fall_pulse) begin
      trst_q <= !((op_q == OP_RESET) && (per_nxt < 8'(RESET_LEN - 1)));
    end
  end

  assign jtag_trst_n = trst_q & ~rst;
`endif

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Bench for jtag_host_shifter: behavioural TAP and a TDI->TDO one-period loop act as targets.
module tb_jtag_host_shifter;
  localparam int CD = 2;
  localparam int ML = 64;
  localparam logic [31:0] IDCODE = 32'h1E200A6D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [6:0]    cmd_len = 7'd0;
  logic [ML-1:0] cmd_tdi = '0;
  logic          cmd_ready, rsp_valid, busy, jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
  logic [ML-1:0] rsp_tdo;
`ifdef JTAG_HOST_TRST_EN
  logic          jtag_trst_n;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  jtag_host_shifter #(.CLK_DIV(CD), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_tdi(cmd_tdi), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tdo(rsp_tdo), .busy(busy), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms),
    .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
`ifdef JTAG_HOST_TRST_EN
    , .jtag_trst_n(jtag_trst_n)
`endif
  );

  // Targets: a 16-state TAP with 5-bit IR and IDCODE, or a loop whose TDO is TDI one period late.
  logic       tap_mode = 1'b0;
  logic       loop_cap = 1'b0, loop_tdo = 1'b0, tap_tdo = 1'b0;
  int         tap_st = 0;
  logic [4:0] ir = 5'd1, ir_sr = 5'd0;
  logic [31:0] dr_sr = 32'd0;
  logic       seen_tms[$];
  logic       seen_tdi[$];
  logic       seen_trst[$];

  assign jtag_tdo = tap_mode ? tap_tdo : loop_tdo;

  function automatic int tap_next(int s, logic tms);
    case (s)
      0:  return tms ? 0 : 1;
      1:  return tms ? 2 : 1;
      2:  return tms ? 9 : 3;
      3:  return tms ? 5 : 4;
      4:  return tms ? 5 : 4;
      5:  return tms ? 8 : 6;
      6:  return tms ? 7 : 6;
      7:  return tms ? 8 : 4;
      8:  return tms ? 2 : 1;
      9:  return tms ? 0 : 10;
      10: return tms ? 12 : 11;
      11: return tms ? 12 : 11;
      12: return tms ? 15 : 13;
      13: return tms ? 14 : 13;
      14: return tms ? 15 : 11;
      15: return tms ? 2 : 1;
      default: return 0;
    endcase
  endfunction

  always @(posedge jtag_tck) begin
    seen_tms.push_back(jtag_tms);
    seen_tdi.push_back(jtag_tdi);
`ifdef JTAG_HOST_TRST_EN
    seen_trst.push_back(jtag_trst_n);
`endif
    loop_cap <= jtag_tdi;
    case (tap_st)
      0:  ir <= 5'd1;
      3:  dr_sr <= (ir == 5'd1) ? IDCODE : 32'd0;
      4:  dr_sr <= {jtag_tdi, dr_sr[31:1]};
      10: ir_sr <= 5'b00001;
      11: ir_sr <= {jtag_tdi, ir_sr[4:1]};
      15: ir <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, jtag_tms);
  end

  always @(negedge jtag_tck) begin
    loop_tdo <= loop_cap;
    tap_tdo  <= (tap_st == 11) ? ir_sr[0] : (tap_st == 4) ? dr_sr[0] : 1'b0;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ML-1:0] loop_exp(int len, logic [ML-1:0] tdi);
    logic [ML-1:0] r;
    int L;
    r = '0;
    L = (len > ML) ? ML : len;
    for (int i = 1; i < L; i++) r[i] = tdi[i-1];
    return r;
  endfunction

  // Issue one command and check timing, TMS/TDI waveform and response; leaves the response pending.
  task automatic run(input logic [1:0] op, input int len, input logic [ML-1:0] tdi,
                     input logic [ML-1:0] exp_tdo, input string tag);
    int L, hdr, p, lat;
    logic [127:0] et, ed, gt, gd;
    L = (len > ML) ? ML : len;
    et = '0; ed = '0; gt = '0; gd = '0; p = 0; hdr = 0;
    case (op)
      2'd0: begin for (int i = 0; i < 5; i++) et[i] = 1'b1; p = 6; end
      2'd3: p = L;
      default: if (L > 0) begin
        hdr = (op == 2'd1) ? 4 : 3;
        et[0] = 1'b1;
        if (op == 2'd1) et[1] = 1'b1;
        for (int i = 0; i < L; i++) ed[hdr+i] = tdi[i];
        et[hdr+L-1] = 1'b1;
        et[hdr+L]   = 1'b1;
        p = hdr + L + 2;
      end
    endcase
    seen_tms.delete(); seen_tdi.delete(); seen_trst.delete();
    cmd_op = op; cmd_len = 7'(len); cmd_tdi = tdi; cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
    chk({tag, "_ready"}, 128'(cmd_ready), 128'(1));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, "_busy"}, 128'(busy), 128'(p > 0));
      if (rsp_valid) begin lat = k; break; end
    end
    chk({tag, "_latency"}, 128'(lat), 128'(2 * CD * p));
    chk({tag, "_tdo"}, 128'(rsp_tdo), 128'(exp_tdo));
    chk({tag, "_periods"}, 128'(seen_tms.size()), 128'(p));
    for (int i = 0; i < seen_tms.size() && i < 128; i++) begin
      gt[i] = seen_tms[i];
      gd[i] = seen_tdi[i];
    end
    chk({tag, "_tms"}, gt, et);
    chk({tag, "_tdi"}, gd, ed);
    chk({tag, "_tck_idle"}, 128'(jtag_tck), 128'(0));
    if (p > 0) chk({tag, "_tms_hold"}, 128'(jtag_tms), 128'(0));
`ifdef JTAG_HOST_TRST_EN
    if (op == 2'd0) begin
      gt = '0;
      for (int i = 0; i < seen_trst.size() && i < 128; i++) gt[i] = seen_trst[i];
      chk({tag, "_trst"}, gt, 128'h20);
    end
`endif
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_ack", 128'(cmd_ready), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [ML-1:0] d, held;
    logic [1:0]    op;
    int            len, lat;
    logic          seen_v;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tck", 128'(jtag_tck), 128'(0));
    chk("rst_tms", 128'(jtag_tms), 128'(1));
    chk("rst_tdi", 128'(jtag_tdi), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_tdo", 128'(rsp_tdo), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
`ifdef JTAG_HOST_TRST_EN
    chk("rst_trst", 128'(jtag_trst_n), 128'(0));
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 128'(cmd_ready), 128'(1));

    // IDCODE read through the behavioural TAP
    tap_mode = 1'b1;
    run(2'd0, 0, '0, '0, "tap_reset");
    chk("tap_in_rti", 128'(tap_st), 128'(1));
    ack();
    run(2'd1, 5, 64'h1, 64'h1, "ir_idcode");
    ack();
    run(2'd2, 32, '0, {32'd0, IDCODE}, "dr_idcode");
    ack();
    tap_mode = 1'b0;

    run(2'd2, 8, 64'hA5, 64'h4A, "dr_a5");
    ack();

    // Response back-pressure with a command waiting
    d = {$urandom, $urandom};
    run(2'd2, 20, d, loop_exp(20, d), "dr_hold");
    held = rsp_tdo;
    cmd_op = 2'd3; cmd_len = 7'd3; cmd_tdi = '0; cmd_valid = 1'b1;
    seen_v = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cmd_ready || !rsp_valid || rsp_tdo !== held) seen_v = 1'b1;
    end
    chk("hold_stall", 128'(seen_v), 128'(0));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("hold_ready_next", 128'(cmd_ready), 128'(1));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) chk("hold_busy", 128'(busy), 128'(1));
      if (rsp_valid) begin lat = k; break; end
    end
    chk("hold_idle_latency", 128'(lat), 128'(2 * CD * 3));
    ack();

    // Zero-length and clamped commands
    run(2'd3, 0, '0, '0, "idle_l0");
    ack();
    run(2'd2, 0, 64'hFF, '0, "dr_l0");
    ack();
    run(2'd1, 0, 64'hFF, '0, "ir_l0");
    ack();
    run(2'd3, 5, '0, '0, "idle_l5");
    ack();
    d = {$urandom, $urandom};
    run(2'd2, 100, d, loop_exp(64, d), "dr_l100");
    ack();

    // Randomised commands against the loop target
    for (int n = 0; n < 10; n++) begin
      op  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 64);
      d   = {$urandom, $urandom};
      run(op, len, d, (op == 2'd1 || op == 2'd2) ? loop_exp(len, d) : '0,
          $sformatf("rnd%0d_op%0d_l%0d", n, op, len));
      ack();
    end

    // Reset during shift period 3 of a DR scan
    seen_tms.delete(); seen_tdi.delete(); seen_trst.delete();
    cmd_op = 2'd2; cmd_len = 7'd8; cmd_tdi = 64'hFF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < 200 && seen_tms.size() < 7; k++) @(negedge clk);
    chk("abort_reached_shift3", 128'(seen_tms.size()), 128'(7));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tck", 128'(jtag_tck), 128'(0));
    chk("abort_tms", 128'(jtag_tms), 128'(1));
    chk("abort_tdi", 128'(jtag_tdi), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("abort_rsp_tdo", 128'(rsp_tdo), 128'(0));
`ifdef JTAG_HOST_TRST_EN
    chk("abort_trst", 128'(jtag_trst_n), 128'(0));
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 128'(cmd_ready), 128'(1));
    seen_v = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen_v = 1'b1;
    end
    chk("abort_no_response", 128'(seen_v), 128'(0));
    run(2'd0, 0, '0, '0, "recover_reset");
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
